divider_iter: RTL and testbench

//  Parametrised, synthesisable iterative fixed-point divider: unsigned integer dividend / signed divisor.

---
 rtl/divider_iter_pkg.sv | 27 ++
 rtl/divider_iter_if.sv | 33 +++
 rtl/divider_iter_step.sv | 18 +
 rtl/divider_iter.sv | 157 +++++++++++++++
 tb/tb_divider_iter.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/divider_iter_pkg.sv
// Shared definitions for the iterative fixed-point divider.
//   state_t      : FSM state encoding (IDLE / CALC / DONE)
//   DEF_*        : default width constants for the raycaster instance
//   clog2()      : ceiling log2, used to size the iteration counter
package divider_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_DEND_W = 4;
  localparam int unsigned DEF_DSOR_W = 32;
  localparam int unsigned DEF_QUOT_W = 4;
  localparam int unsigned DEF_FRAC_W = 32;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/divider_iter_if.sv
// Handshake and data bundle of the iterative divider.
//   nd/dividend/divisor          : request side (driven by the master)
//   rfd                          : divider can accept a request
//   rdy/quotient/fractional/
//   divide_by_zero/overflow      : result side (driven by the slave)
interface divider_iter_if
  import divider_iter_pkg::*;
#(
  parameter int unsigned DEND_W = DEF_DEND_W,
  parameter int unsigned DSOR_W = DEF_DSOR_W,
  parameter int unsigned QUOT_W = DEF_QUOT_W,
  parameter int unsigned FRAC_W = DEF_FRAC_W
);
  logic              nd;
  logic              rfd;
  logic [DEND_W-1:0] dividend;
  logic [DSOR_W-1:0] divisor;
  logic              rdy;
  logic [QUOT_W-1:0] quotient;
  logic [FRAC_W-1:0] fractional;
  logic              divide_by_zero;
  logic              overflow;

  modport master (
    output nd, dividend, divisor,
    input  rfd, rdy, quotient, fractional, divide_by_zero, overflow
  );

  modport slave (
    input  nd, dividend, divisor,
    output rfd, rdy, quotient, fractional, divide_by_zero, overflow
  );
endinterface

// File: rtl/divider_iter_step.sv
// One combinational restoring-division step.
//   rem_in   : partial remainder already shifted left with the next dividend bit
//   dsor_abs : divisor magnitude
//   rem_out  : remainder after the conditional subtract
//   qbit     : quotient bit produced by this step
module divider_step #(
  parameter int unsigned W = 33
) (
  input  logic [W-1:0] rem_in,
  input  logic [W-1:0] dsor_abs,
  output logic [W-1:0] rem_out,
  output logic         qbit
);
  always_comb begin
    qbit    = (rem_in >= dsor_abs);
    rem_out = qbit ? (rem_in - dsor_abs) : rem_in;
  end
endmodule

// File: rtl/divider_iter.sv
// Iterative fixed-point divider: unsigned integer dividend / signed divisor,
// signed QUOT_W.FRAC_W result truncated toward zero.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of divider_iter_if (nd/rfd request handshake,
//              rdy pulse with quotient/fractional/divide_by_zero/overflow)
// Accept edge 0 -> N CALC cycles -> one DONE cycle with rdy=1 and rfd=1,
// so a new request can be taken on the edge that ends the rdy cycle.
module divider_iter
  import divider_iter_pkg::*;
#(
  parameter int unsigned DEND_W = DEF_DEND_W,
  parameter int unsigned DSOR_W = DEF_DSOR_W,
  parameter int unsigned QUOT_W = DEF_QUOT_W,
  parameter int unsigned FRAC_W = DEF_FRAC_W
) (
  input logic            clk,
  input logic            rst,
  divider_iter_if.slave  bus
);
  localparam int unsigned N     = DEND_W + FRAC_W;
  localparam int unsigned RW    = QUOT_W + FRAC_W;
  localparam int unsigned W     = DSOR_W + 1;
  localparam int unsigned CNT_W = clog2(N + 1);
  localparam logic [N-1:0] HALF = N'(1) << (RW - 1);

  state_t            state, state_nxt;
  logic              accept, last_step, rfd, rdy;
  logic [CNT_W-1:0]  cnt;
  logic [N-1:0]      src;
  logic [N-2:0]      quo;
  logic [W-1:0]      rem, dsor_r, rem_shift, rem_step;
  logic [W-1:0]      dsor_ext, dsor_abs;
  logic              sign_r, dbz_r, qbit;
  logic [N-1:0]      mag, mag_neg;
  logic [RW-1:0]     res;
  logic              ovf;
  logic [QUOT_W-1:0] quot_o;
  logic [FRAC_W-1:0] frac_o;
  logic              dbz_o, ovf_o;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    rfd       = 1'b0;
    rdy       = 1'b0;
    last_step = 1'b0;
    case (state)
      IDLE: begin
        rfd = 1'b1;
        if (bus.nd) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        last_step = (cnt == CNT_W'(N - 1));
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        rfd = 1'b1;
        rdy = 1'b1;
        if (bus.nd) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sign-extend one bit before negating so the most negative divisor
  // yields its true magnitude.
  always_comb begin
    dsor_ext = {bus.divisor[DSOR_W-1], bus.divisor};
    dsor_abs = bus.divisor[DSOR_W-1] ? (~dsor_ext + 1'b1) : dsor_ext;
  end

  // Remainder stays below |divisor| <= 2^(DSOR_W-1), so dropping its MSB
  // on the shift loses nothing.
  assign rem_shift = W'({rem, src[N-1]});

  divider_step #(.W(W)) u_step (
    .rem_in   (rem_shift),
    .dsor_abs (dsor_r),
    .rem_out  (rem_step),
    .qbit     (qbit)
  );

  // Final quotient includes the bit produced in the last CALC cycle, so the
  // result registers are loaded on that edge and are valid during DONE.
  always_comb begin
    mag     = {quo, qbit};
    mag_neg = -mag;
    if (dbz_r) begin
      res = {1'b0, {(RW-1){1'b1}}};
      ovf = 1'b0;
    end else if (sign_r) begin
      res = mag_neg[RW-1:0];
      ovf = (mag > HALF);
    end else begin
      res = mag[RW-1:0];
      ovf = (mag >= HALF);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      src    <= '0;
      quo    <= '0;
      rem    <= '0;
      dsor_r <= '0;
      sign_r <= 1'b0;
      dbz_r  <= 1'b0;
      quot_o <= '0;
      frac_o <= '0;
      dbz_o  <= 1'b0;
      ovf_o  <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      src    <= {bus.dividend, {FRAC_W{1'b0}}};
      quo    <= '0;
      rem    <= '0;
      dsor_r <= dsor_abs;
      sign_r <= bus.divisor[DSOR_W-1];
      dbz_r  <= (bus.divisor == '0);
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      src <= src << 1;
      rem <= rem_step;
      quo <= mag[N-2:0];
      if (last_step) begin
        quot_o <= res[RW-1:FRAC_W];
        frac_o <= res[FRAC_W-1:0];
        dbz_o  <= dbz_r;
        ovf_o  <= ovf;
      end
    end
  end

  assign bus.rfd            = rfd;
  assign bus.rdy            = rdy;
  assign bus.quotient       = quot_o;
  assign bus.fractional     = frac_o;
  assign bus.divide_by_zero = dbz_o;
  assign bus.overflow       = ovf_o;

endmodule

// File: tb/tb_divider_iter.sv
// Directed bench for divider_iter with default widths (4 / 32 / 4.32).
// Edge numbering: the accept edge is 0; "rdy at edge k" means rdy is high
// when sampled by edge k (observed here on the preceding falling edge).
module tb_divider_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  divider_iter_if #(.DEND_W(4), .DSOR_W(32), .QUOT_W(4), .FRAC_W(32)) bus ();

  divider_iter #(.DEND_W(4), .DSOR_W(32), .QUOT_W(4), .FRAC_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  dend;
    logic [31:0] dsor;
    logic [3:0]  q;
    logic [31:0] f;
    logic        dbz;
    logic        ovf;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request from idle and return how many edges until rdy.
  task automatic run_op(input logic [3:0] dend, input logic [31:0] dsor, output int lat);
    @(negedge clk);
    bus.nd       = 1'b1;
    bus.dividend = dend;
    bus.divisor  = dsor;
    @(posedge clk);
    #1 bus.nd = 1'b0;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.rdy === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  vec_t vecs[12];
  int   lat;
  int   pulses;

  initial begin
    vecs[0]  = '{4'd1,  32'd2,          4'h0, 32'h8000_0000, 1'b0, 1'b0};
    vecs[1]  = '{4'd3,  32'hFFFF_FFFF,  4'hD, 32'h0000_0000, 1'b0, 1'b0};
    vecs[2]  = '{4'd5,  32'd0,          4'h7, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[3]  = '{4'd15, 32'd1,          4'hF, 32'h0000_0000, 1'b0, 1'b1};
    vecs[4]  = '{4'd8,  32'hFFFF_FFFF,  4'h8, 32'h0000_0000, 1'b0, 1'b0};
    vecs[5]  = '{4'd8,  32'd1,          4'h8, 32'h0000_0000, 1'b0, 1'b1};
    vecs[6]  = '{4'd7,  32'h8000_0000,  4'hF, 32'hFFFF_FFF2, 1'b0, 1'b0};
    vecs[7]  = '{4'd1,  32'd3,          4'h0, 32'h5555_5555, 1'b0, 1'b0};
    vecs[8]  = '{4'd1,  32'hFFFF_FFFD,  4'hF, 32'hAAAA_AAAB, 1'b0, 1'b0};
    vecs[9]  = '{4'd10, 32'hFFFF_FFFC,  4'hD, 32'h8000_0000, 1'b0, 1'b0};
    vecs[10] = '{4'd0,  32'hFFFF_FFF9,  4'h0, 32'h0000_0000, 1'b0, 1'b0};
    vecs[11] = '{4'd7,  32'd7,          4'h1, 32'h0000_0000, 1'b0, 1'b0};

    bus.nd = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_rfd", 64'(bus.rfd), 64'd1);
    check("reset_rdy", 64'(bus.rdy), 64'd0);
    check("reset_q",   64'(bus.quotient), 64'd0);
    check("reset_f",   64'(bus.fractional), 64'd0);
    check("reset_dbz", 64'(bus.divide_by_zero), 64'd0);
    check("reset_ovf", 64'(bus.overflow), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].dend, vecs[i].dsor, lat);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'd37);
      check($sformatf("v%0d_rfd", i), 64'(bus.rfd), 64'd1);
      check($sformatf("v%0d_q", i), 64'(bus.quotient), 64'(vecs[i].q));
      check($sformatf("v%0d_f", i), 64'(bus.fractional), 64'(vecs[i].f));
      check($sformatf("v%0d_dbz", i), 64'(bus.divide_by_zero), 64'(vecs[i].dbz));
      check($sformatf("v%0d_ovf", i), 64'(bus.overflow), 64'(vecs[i].ovf));
      @(negedge clk);
      check($sformatf("v%0d_rdy_pulse", i), 64'(bus.rdy), 64'd0);
      check($sformatf("v%0d_hold_f", i), 64'(bus.fractional), 64'(vecs[i].f));
    end

    // nd held high for 100 cycles: accepts at edges 0, 37, 74
    @(negedge clk);
    bus.nd       = 1'b1;
    bus.dividend = 4'd1;
    bus.divisor  = 32'd2;
    @(posedge clk);
    pulses = 0;
    for (int k = 1; k < 100; k++) begin
      @(negedge clk);
      if (bus.rdy === 1'b1) pulses++;
      check($sformatf("b2b_rfd_e%0d", k), 64'(bus.rfd), 64'((k % 37) == 0));
      check($sformatf("b2b_rdy_e%0d", k), 64'(bus.rdy), 64'((k % 37) == 0));
    end
    check("b2b_pulses", 64'(pulses), 64'd2);
    check("b2b_f", 64'(bus.fractional), 64'h8000_0000);
    bus.nd = 1'b0;

    // Drain the op still in flight
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.rfd === 1'b1) break;
    end
    @(negedge clk);
    check("drain_idle", 64'(bus.rfd), 64'd1);

    // Reset during CALC drops the op
    bus.nd       = 1'b1;
    bus.dividend = 4'd3;
    bus.divisor  = 32'd5;
    @(posedge clk);
    #1 bus.nd = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_calc_rfd", 64'(bus.rfd), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_calc_rfd", 64'(bus.rfd), 64'd1);
    check("rst_calc_rdy", 64'(bus.rdy), 64'd0);
    check("rst_calc_q",   64'(bus.quotient), 64'd0);
    check("rst_calc_f",   64'(bus.fractional), 64'd0);
    check("rst_calc_dbz", 64'(bus.divide_by_zero), 64'd0);
    check("rst_calc_ovf", 64'(bus.overflow), 64'd0);
    pulses = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.rdy === 1'b1) pulses++;
    end
    check("dropped_no_rdy", 64'(pulses), 64'd0);

    // Reset coincident with nd: request not taken
    bus.nd       = 1'b1;
    bus.dividend = 4'd2;
    bus.divisor  = 32'd1;
    rst          = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    bus.nd = 1'b0;
    @(negedge clk);
    check("rst_vs_nd_rfd", 64'(bus.rfd), 64'd1);
    pulses = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (bus.rdy === 1'b1) pulses++;
    end
    check("rst_vs_nd_no_rdy", 64'(pulses), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
